// File: rtl/axis_uart_rx_framer.sv
// UART receiver that frames bytes into an AXI-Stream image of R_I*C_I pixels.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module axis_uart_rx_framer #(
  parameter int unsigned CLOCKS_PER_PULSE = 8680,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned R_I              = 7,
  parameter int unsigned C_I              = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     parity_err
);

  localparam int unsigned TIMER_W = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BIT_W   = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int unsigned N       = R_I * C_I;
  localparam int unsigned PIX_W   = (N > 1) ? $clog2(N) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(N - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
  } state_e;
`endif

  state_e                   state_q, state_d;
  logic [1:0]               sync_q;
  logic                     rx_s;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] shreg_q, shreg_d;
  logic                     stop_sample_c;
  logic                     par_bad_c;
  logic                     good_c;

  logic [BITS_PER_WORD-1:0] tdata_q, tdata_d;
  logic                     tvalid_q, tvalid_d;
  logic                     tlast_q, tlast_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic [PIX_W-1:0]         pix_q, pix_d;

`ifdef UART_RX_PARITY_EN
  logic                     par_q, par_d;
  logic                     parity_err_q, parity_err_d;
`endif

  assign rx_s = sync_q[1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, bit timer and shift register
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + TIMER_W'(1);
    bit_d         = bit_q;
    shreg_d       = shreg_q;
    stop_sample_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d         = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        bit_d   = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (timer_q == TIMER_HALF) begin
          timer_d = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          shreg_d = BITS_PER_WORD'({rx_s, shreg_q} >> 1);
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (timer_q == TIMER_LAST) begin
          timer_d       = '0;
          stop_sample_c = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output register, error pulses and pixel counter
  always_comb begin
    par_bad_c   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_c   = par_q != (^shreg_q);
    parity_err_d = stop_sample_c && par_bad_c;
`endif
    good_c      = stop_sample_c && rx_s && !par_bad_c;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q && !m_axis_tready;
    overrun_d   = 1'b0;
    frame_err_d = stop_sample_c && !rx_s;
    pix_d       = pix_q;
    if (good_c) begin
      if (tvalid_q && !m_axis_tready) begin
        overrun_d = 1'b1;
      end else begin
        tvalid_d = 1'b1;
        tdata_d  = shreg_q;
      end
    end
    if (tvalid_q && m_axis_tready) begin
      pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + PIX_W'(1);
    end
    tlast_d = tvalid_d && (pix_d == PIX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      timer_q     <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      pix_q       <= '0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      pix_q       <= pix_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_axis_uart_rx_framer.sv
// Self-checking bench for axis_uart_rx_framer: vector table plus corner-case sequences.
module tb_axis_uart_rx_framer;

  localparam int unsigned CPP = 16;
  localparam int unsigned N   = 4;
  localparam int unsigned GAP = 12;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Beat rises 3 cycles after the nominal mid-stop point
  localparam int LAT = (NBITS - 1) * CPP + CPP / 2 + 3;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    bit         rst_before;
    logic [7:0] data;
    bit         stop_ok;
    bit         exp_beat;
    bit         exp_last;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  axis_uart_rx_framer #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (8),
    .R_I             (2),
    .C_I             (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed beats and pulse counts, written only by the monitor
  logic [7:0] obs_data [0:255];
  logic       obs_last [0:255];
  int         obs_cyc  [0:255];
  int         obs_wr = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;

  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready && obs_wr < 256) begin
      obs_data[obs_wr] = m_axis_tdata;
      obs_last[obs_wr] = m_axis_tlast;
      obs_cyc[obs_wr]  = cyc;
      obs_wr           = obs_wr + 1;
    end
    if (frame_err)  fe_cnt = fe_cnt + 1;
    if (overrun)    ov_cnt = ov_cnt + 1;
    if (parity_err) pe_cnt = pe_cnt + 1;
  end

  beat_t exp_q[$];
  int    exp_pix = 0;
  int    obs_rd = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    start_cyc = 0;
  int    last_beat_cyc = 0;
  vec_t  vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.last = last;
    exp_q.push_back(b);
    exp_pix = (exp_pix + 1) % N;
  endtask

  task automatic push_model(input logic [7:0] d);
    push(d, exp_pix == N - 1);
  endtask

  task automatic consume();
    beat_t e;
    while (obs_rd < obs_wr) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL beat_unexpected: got data=0x%02h last=%0d, required no beat",
                 obs_data[obs_rd], obs_last[obs_rd]);
      end else begin
        e = exp_q.pop_front();
        if (obs_data[obs_rd] !== e.data || obs_last[obs_rd] !== e.last) begin
          n_fail = n_fail + 1;
          $display("FAIL beat: got data=0x%02h last=%0d, required data=0x%02h last=%0d",
                   obs_data[obs_rd], obs_last[obs_rd], e.data, e.last);
        end
      end
      last_beat_cyc = obs_cyc[obs_rd];
      obs_rd = obs_rd + 1;
    end
  endtask

  // Compare beats until the scoreboard empties; stays at least 20 cycles to catch strays
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      n = n + 1;
      consume();
      if (exp_q.size() == 0 && n >= 20) break;
    end
    if (exp_q.size() != 0) begin
      n_cmp  = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL drain_timeout: got %0d beats still missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPP) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    @(posedge clk); #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ !par_ok);
`else
    if (!par_ok) $display("note: parity request ignored in 8N1 build");
`endif
    drive_bit(stop_ok);
    rx = 1'b1;
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk); #1;
    check("rst_tvalid",     32'(m_axis_tvalid), 32'd0);
    check("rst_tlast",      32'(m_axis_tlast),  32'd0);
    check("rst_tdata",      32'(m_axis_tdata),  32'd0);
    check("rst_frame_err",  32'(frame_err),     32'd0);
    check("rst_overrun",    32'(overrun),       32'd0);
    check("rst_parity_err", 32'(parity_err),    32'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_pix = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fe0, ov0, pe0, diff;
    rst = 1'b1;
    rx = 1'b1;
    m_axis_tready = 1'b1;

    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h03, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h04, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h05, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h66, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 8'h77, 1'b1, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst_before) do_reset();
      fe0 = fe_cnt;
      if (vecs[i].exp_beat) push(vecs[i].data, vecs[i].exp_last);
      send(vecs[i].data, vecs[i].stop_ok, 1'b1);
      drain(200);
      check("frame_err_pulses", 32'(fe_cnt - fe0), vecs[i].stop_ok ? 32'd0 : 32'd1);
      if (i == 0) begin
        diff = last_beat_cyc - start_cyc;
        n_cmp = n_cmp + 1;
        if (diff < LAT - 1 || diff > LAT + 1) begin
          n_fail = n_fail + 1;
          $display("FAIL first_beat_latency: got %0d cycles, required %0d +/- 1", diff, LAT);
        end
      end
    end

    // Overrun: second byte arrives while the first is still held
    m_axis_tready = 1'b0;
    ov0 = ov_cnt;
    push_model(8'h11);
    send(8'h11, 1'b1, 1'b1);
    send(8'h22, 1'b1, 1'b1);
    check("overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("held_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("held_tdata",  32'(m_axis_tdata),  32'h11);
    m_axis_tready = 1'b1;
    drain(100);
    check("tvalid_after_drain", 32'(m_axis_tvalid), 32'd0);

    // Short low glitch on an idle line
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    drain(25);
    check("glitch_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_overrun",   32'(ov_cnt - ov0), 32'd0);
    check("glitch_tvalid",    32'(m_axis_tvalid), 32'd0);

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    push_model(8'h07);
    send(8'h07, 1'b1, 1'b1);
    drain(100);
    check("parity_good_pulses", 32'(pe_cnt - pe0), 32'd0);
    pe0 = pe_cnt;
    send(8'h07, 1'b1, 1'b0);
    drain(40);
    check("parity_bad_pulses", 32'(pe_cnt - pe0), 32'd1);
    check("parity_bad_tvalid", 32'(m_axis_tvalid), 32'd0);
`endif

    // Reset mid-byte with a beat pending and pix away from 0
    m_axis_tready = 1'b0;
    send(8'h12, 1'b1, 1'b1);
    check("pending_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("pending_tdata",  32'(m_axis_tdata),  32'h12);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (5 * CPP) @(posedge clk);
    #1;
    do_reset();
    m_axis_tready = 1'b1;
    pe0 = pe_cnt;
    push_model(8'hC3);
    send(8'hC3, 1'b1, 1'b1);
    push_model(8'hD4);
    send(8'hD4, 1'b1, 1'b1);
    push_model(8'hE5);
    send(8'hE5, 1'b1, 1'b1);
    push_model(8'hF6);
    send(8'hF6, 1'b1, 1'b1);
    drain(200);
    check("post_reset_parity_err", 32'(pe_cnt - pe0), 32'd0);

`ifndef UART_RX_PARITY_EN
    check("parity_err_total", 32'(pe_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
